// File: rtl/fft_pkg.sv
// Shared sizing constants and controller state type for the FFT peak detector.
package fft_pkg;
    localparam int FFT_SIZE   = 256;
    localparam int DATA_WIDTH = 24;
    localparam int BIN_IDX_W  = $clog2(FFT_SIZE);
    localparam int MAG_W      = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DRAIN  = 2'd2,
        REPORT = 2'd3
    } peak_state_e;
endpackage

// File: rtl/fft_mag_sq.sv
// Two-stage registered magnitude-squared (re^2 + im^2) with a tag carried alongside.
// Valid bits move every cycle; data registers only load when their input is valid.
module fft_mag_sq
    import fft_pkg::*;
#(
    parameter int IN_W  = DATA_WIDTH,
    parameter int OUT_W = MAG_W,
    parameter int TAG_W = BIN_IDX_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             data_valid,
    input  logic [IN_W-1:0]  data_real,
    input  logic [IN_W-1:0]  data_imag,
    input  logic [TAG_W-1:0] data_tag,
    output logic             mag_valid,
    output logic [OUT_W-1:0] mag,
    output logic [TAG_W-1:0] mag_tag
);
    logic signed [OUT_W-1:0] re_ext_s;
    logic signed [OUT_W-1:0] im_ext_s;
    logic signed [OUT_W-1:0] re_sq_r;
    logic signed [OUT_W-1:0] im_sq_r;
    logic                    s1_valid_r;
    logic                    s2_valid_r;
    logic [TAG_W-1:0]        s1_tag_r;
    logic [TAG_W-1:0]        s2_tag_r;
    logic [OUT_W-1:0]        sum_r;

    // Sign-extend operands so the squares are formed at full output width.
    always_comb begin
        re_ext_s = OUT_W'($signed(data_real));
        im_ext_s = OUT_W'($signed(data_imag));
    end

    // Stage 1: register the two squares and the bin tag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_r <= 1'b0;
            re_sq_r    <= {OUT_W{1'b0}};
            im_sq_r    <= {OUT_W{1'b0}};
            s1_tag_r   <= {TAG_W{1'b0}};
        end else begin
            s1_valid_r <= data_valid;
            if (data_valid) begin
                re_sq_r  <= re_ext_s * re_ext_s;
                im_sq_r  <= im_ext_s * im_ext_s;
                s1_tag_r <= data_tag;
            end
        end
    end

    // Stage 2: both squares are non-negative, so the unsigned sum fits OUT_W bits.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s2_valid_r <= 1'b0;
            sum_r      <= {OUT_W{1'b0}};
            s2_tag_r   <= {TAG_W{1'b0}};
        end else begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                sum_r    <= $unsigned(re_sq_r) + $unsigned(im_sq_r);
                s2_tag_r <= s1_tag_r;
            end
        end
    end

    assign mag_valid = s2_valid_r;
    assign mag       = sum_r;
    assign mag_tag   = s2_tag_r;
endmodule

// File: rtl/fft_peak_detector.sv
// Streams one FFT frame of complex bins and reports the index and magnitude-squared
// of the strongest bin inside the search window, with valid/ready on both sides.
module fft_peak_detector #(
    parameter int DATA_WIDTH  = fft_pkg::DATA_WIDTH,
    parameter int FFT_SIZE    = fft_pkg::FFT_SIZE,
    parameter int SEARCH_BINS = 128,
    parameter int SKIP_DC     = 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [DATA_WIDTH-1:0]       bin_real_i,
    input  logic [DATA_WIDTH-1:0]       bin_imag_i,
    input  logic                        bin_valid_i,
    output logic                        bin_ready_o,
    output logic [$clog2(FFT_SIZE)-1:0] peak_bin_o,
    output logic [2*DATA_WIDTH-1:0]     peak_mag_o,
    output logic                        result_valid_o,
    input  logic                        result_ready_i,
    output logic                        busy_o,
    output logic [5:0]                  debug_leds_o
);
    import fft_pkg::*;

    localparam int IDX_W = $clog2(FFT_SIZE);
    localparam int M_W   = 2 * DATA_WIDTH;
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(FFT_SIZE - 1);
    localparam logic [IDX_W-1:0] FIRST_SEARCH = IDX_W'(SKIP_DC);

    peak_state_e      state_r;
    peak_state_e      state_next_s;
    logic [IDX_W-1:0] bin_cnt_r;
    logic             drain_cnt_r;
    logic             xfer_s;
    logic             last_xfer_s;
    logic             frame_start_s;
    logic             report_entry_s;
    logic             mag_valid_s;
    logic [M_W-1:0]   mag_s;
    logic [IDX_W-1:0] mag_idx_s;
    logic             in_range_s;
    logic             better_s;
    logic [M_W-1:0]   max_r;
    logic [M_W-1:0]   max_next_s;
    logic [IDX_W-1:0] max_idx_r;
    logic [IDX_W-1:0] max_idx_next_s;
    logic             bin_ready_r;
    logic             result_valid_r;
    logic             busy_r;
    logic [IDX_W-1:0] peak_bin_r;
    logic [M_W-1:0]   peak_mag_r;

    assign xfer_s         = bin_valid_i & bin_ready_r;
    assign last_xfer_s    = xfer_s & (bin_cnt_r == LAST_IDX);
    assign frame_start_s  = xfer_s & (state_r == IDLE);
    assign report_entry_s = (state_r == DRAIN) & (state_next_s == REPORT);

    fft_mag_sq #(
        .IN_W  (DATA_WIDTH),
        .OUT_W (M_W),
        .TAG_W (IDX_W)
    ) u_mag_sq (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .data_valid (xfer_s),
        .data_real  (bin_real_i),
        .data_imag  (bin_imag_i),
        .data_tag   (bin_cnt_r),
        .mag_valid  (mag_valid_s),
        .mag        (mag_s),
        .mag_tag    (mag_idx_s)
    );

    // Controller state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; DRAIN covers the two magnitude pipeline stages.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (last_xfer_s) state_next_s = DRAIN;
                else if (xfer_s) state_next_s = ACCUM;
                else             state_next_s = IDLE;
            end
            ACCUM: begin
                if (last_xfer_s) state_next_s = DRAIN;
                else             state_next_s = ACCUM;
            end
            DRAIN: begin
                if (drain_cnt_r) state_next_s = REPORT;
                else             state_next_s = DRAIN;
            end
            REPORT: begin
                if (result_valid_r && result_ready_i) state_next_s = IDLE;
                else                                  state_next_s = REPORT;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Implicit bin index and drain cycle counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bin_cnt_r   <= {IDX_W{1'b0}};
            drain_cnt_r <= 1'b0;
        end else begin
            if (last_xfer_s)  bin_cnt_r <= {IDX_W{1'b0}};
            else if (xfer_s)  bin_cnt_r <= bin_cnt_r + IDX_W'(1'b1);
            drain_cnt_r <= (state_r == DRAIN) ? ~drain_cnt_r : 1'b0;
        end
    end

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        in_range_s = (32'(mag_idx_s) >= SKIP_DC) && (32'(mag_idx_s) < SEARCH_BINS);
        better_s   = mag_valid_s && in_range_s && (mag_s > max_r);
        if (better_s) begin
            max_next_s     = mag_s;
            max_idx_next_s = mag_idx_s;
        end else begin
            max_next_s     = max_r;
            max_idx_next_s = max_idx_r;
        end
    end

    // Running maximum, cleared by the first transfer of every frame.
    always_ff @(posedge clk_i) begin
        if (rst_i || frame_start_s) begin
            max_r     <= {M_W{1'b0}};
            max_idx_r <= FIRST_SEARCH;
        end else begin
            max_r     <= max_next_s;
            max_idx_r <= max_idx_next_s;
        end
    end

    // Registered outputs; the peak includes the final compare on REPORT entry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bin_ready_r    <= 1'b1;
            result_valid_r <= 1'b0;
            busy_r         <= 1'b0;
            peak_bin_r     <= {IDX_W{1'b0}};
            peak_mag_r     <= {M_W{1'b0}};
        end else begin
            bin_ready_r    <= (state_next_s == IDLE) || (state_next_s == ACCUM);
            result_valid_r <= (state_next_s == REPORT);
            busy_r         <= (state_next_s != IDLE);
            if (report_entry_s) begin
                peak_bin_r <= max_idx_next_s;
                peak_mag_r <= max_next_s;
            end
        end
    end

    assign bin_ready_o    = bin_ready_r;
    assign result_valid_o = result_valid_r;
    assign busy_o         = busy_r;
    assign peak_bin_o     = peak_bin_r;
    assign peak_mag_o     = peak_mag_r;
    assign debug_leds_o   = peak_bin_r[7:2];
endmodule
